// File: rtl/bc_4bit_down_timer.sv
// Loadable down-counting timer: counts a preset down to zero under en gating,
// then pulses done for one cycle; optionally reloads the preset and repeats.
module bc_4bit_down_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] rld, rld_d;
  logic [WIDTH-1:0] out_d;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      out   <= '0;
      rld   <= '0;
    end else begin
      state <= state_d;
      out   <= out_d;
      rld   <= rld_d;
    end
  end

  // load beats everything but clear; start only matters in IDLE
  always_comb begin
    state_d = state;
    out_d   = out;
    rld_d   = rld;
    if (load) begin
      out_d   = din;
      rld_d   = din;
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_d = (out != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (en) begin
            if (out > WIDTH'(1)) begin
              out_d = out - WIDTH'(1);
            end else begin
              out_d   = '0;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          // reload ignores en so the period stays exactly N+1 cycles
          if (AUTO_RELOAD && (rld != '0)) begin
            out_d   = rld;
            state_d = RUN;
          end else begin
            out_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          out_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/bc_4bit_down_timer.md
# bc_4bit_down_timer

Loadable down-counting timer. It is the counterpart of the team's up-counting `bc_4bit` binary counter. It takes a preset value and counts it down to zero under the same `en` gating, then raises a one-cycle `done` strobe. An optional auto-reload mode repeats the count. It sits beside `bc_4bit` in the counter library and shares its clock and clear conventions, so the two blocks can be used as matched interval generator/measurer pairs.

## Interface
- `WIDTH`, 4: counter and preset width in bits.
- `AUTO_RELOAD`, 0: 1 = restart from the stored preset after each `done`; 0 = stop in IDLE.
- `clk`  in  1  system clock; all registers update on the rising edge.
- `clear`  in  1  reset, asynchronous and active-high; overrides everything while high.
- `en`  in  1  count enable; decrement occurs only on edges where `en`=1.
- `load`  in  1  capture `din` into the preset register and the counter.
- `din`  in  WIDTH  preset value.
- `start`  in  1  begin counting from the current `out`.
- `out`  out  WIDTH  current count (registered).
- `busy`  out  1  high while in RUN.
- `done`  out  1  high for exactly one cycle when the count reaches zero.

## Operation
- State register: IDLE, RUN, DONE. Internal preset register `rld` is WIDTH bits.
- `clear`=1 takes effect immediately, without waiting for `clk`:
  - `out`=0, `rld`=0, state=IDLE, `busy`=0, `done`=0.
  - These are the reset values of every output.
- Priority on each edge: `clear` > `load` > `start` > counting.
- `load`=1 in any state:
  - `out`<=`din`, `rld`<=`din`, state<=IDLE.
  - A pending `done` is cancelled, and `start` on the same edge is ignored.
- IDLE:
  - `start`=1 with `out`!=0 -> RUN.
  - `start`=1 with `out`=0 -> DONE (zero-length interval still produces `done`).
  - `en` has no effect in IDLE; `out` holds.
- RUN:
  - `en`=1 and `out`>1 -> `out`<=`out`-1.
  - `en`=1 and `out`=1 -> `out`<=0, state<=DONE.
  - `en`=0 -> hold `out` and stay in RUN (pause).
  - `start` is ignored in RUN.
- DONE (lasts exactly one cycle):
  - `AUTO_RELOAD`=1 and `rld`!=0 -> `out`<=`rld`, state<=RUN, regardless of `en`.
  - Otherwise -> IDLE with `out`=0.
  - `start` in DONE is ignored.
- Arithmetic: unsigned and modulo 2^WIDTH. `out` never decrements below 0, so there is no wrap to all-ones.
- `busy` = (state==RUN). `done` = (state==DONE). Both are decoded from the state register, which makes them glitch-free registered outputs.

## Timing
- With a preset of N>0, `start` sampled at edge k, and `en` held at 1:
  - `busy` rises after edge k.
  - `out` = N-i after edge k+i.
  - `out`=0 and `done`=1 after edge k+N.
  - `done` falls after edge k+N+1.
- Each cycle with `en`=0 in RUN extends this timeline by one cycle.
- Auto-reload period: N+1 cycles per `done` pulse (N counts plus one DONE cycle).
- `clear` asserted mid-RUN returns outputs to 0 without any clock edge. Deasserting `clear` between edges leaves the block in IDLE with `out`=0.
- `load`, `start` and `en` are sampled only at rising edges. Testbenches change them mid-period (e.g. 1 ns after the falling edge).

## Test plan
- **Reset:** pulse `clear` 1 ns wide between edges during RUN with `out`=5 -> `out`=0000, `busy`=0, `done`=0 immediately; no change on later edges without `start`.
- **Basic count:** `load` `din`=0011, then `start` with `en`=1 -> `out` 0011, 0010, 0001, 0000 on successive edges. `done`=1 for one cycle coincident with 0000, then IDLE.
- **Pause:** preset 0100, `start`, `en` dropped for 3 cycles after the first decrement -> `out` holds 0011 for 3 edges. `done` arrives 3 cycles later than in the ungated case.
- **Zero preset:** `load` 0000, `start` -> `done`=1 one cycle after `start`, `busy` never asserts.
- **Auto-reload (`AUTO_RELOAD`=1):** preset 0010, `en`=1 -> `done` every 3 cycles. Sequence 0010, 0001, 0000(done), 0010, ...
- **Collisions:** `load` 0111 asserted mid-RUN on the same edge as `start` -> `out`=0111, state IDLE, `done`=0. `start` in DONE is ignored.
